// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: a small in-order FIFO of fetched words with
// pc and fault/progbuf flags, first-word fall-through, flushed on any pipeline redirect.
module fetch_queue #(
   parameter int unsigned abits      = 2,
   parameter int unsigned RISCV_ARCH = 64
) (
   input  logic                  i_clk,
   input  logic                  i_nrst,
   input  logic                  i_flush,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic [RISCV_ARCH-1:0] i_in_pc,
   input  logic [63:0]           i_in_instr,
   input  logic                  i_in_load_fault,
   input  logic                  i_in_page_fault_x,
   input  logic                  i_in_progbuf_ena,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [RISCV_ARCH-1:0] o_out_pc,
   output logic [63:0]           o_out_instr,
   output logic                  o_out_load_fault,
   output logic                  o_out_page_fault_x,
   output logic                  o_out_progbuf_ena,
   output logic [abits:0]        o_count
);

   localparam int unsigned DEPTH = 2 ** abits;
   localparam logic [abits:0] CntFull = (abits + 1)'(DEPTH);
   localparam logic [abits:0] CntOne = (abits + 1)'(1);
   localparam logic [abits-1:0] PtrOne = (abits)'(1);

   typedef struct packed {
      logic [RISCV_ARCH-1:0] pc;
      logic [63:0]           instr;
      logic                  load_fault;
      logic                  page_fault_x;
      logic                  progbuf_ena;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           wr_entry;
   entry_t           head;
   logic [abits-1:0] wr_ptr_q, wr_ptr_d;
   logic [abits-1:0] rd_ptr_q, rd_ptr_d;
   logic [abits:0]   count_q, count_d;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   // Ready/valid depend only on registered state and flush, never on the opposite handshake.
   always_comb begin
      full        = (count_q == CntFull);
      empty       = (count_q == '0);
      o_in_ready  = !full && !i_flush;
      o_out_valid = !empty && !i_flush;
      push        = i_in_valid && o_in_ready;
      pop         = o_out_valid && i_out_ready;
   end

   always_comb begin
      wr_entry.pc           = i_in_pc;
      wr_entry.instr        = i_in_instr;
      wr_entry.load_fault   = i_in_load_fault;
      wr_entry.page_fault_x = i_in_page_fault_x;
      wr_entry.progbuf_ena  = i_in_progbuf_ena;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
         end
         if (push && !pop) begin
            count_d = count_q + CntOne;
         end else if (pop && !push) begin
            count_d = count_q - CntOne;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; stale contents are masked by the empty check below.
   always_ff @(posedge i_clk) begin
      if (i_nrst && push) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   always_comb begin
      head               = mem_q[rd_ptr_q];
      o_count            = count_q;
      o_out_pc           = '1;
      o_out_instr        = '0;
      o_out_load_fault   = 1'b0;
      o_out_page_fault_x = 1'b0;
      o_out_progbuf_ena  = 1'b0;
      if (!empty) begin
         o_out_pc           = head.pc;
         o_out_instr        = head.instr;
         o_out_load_fault   = head.load_fault;
         o_out_page_fault_x = head.page_fault_x;
         o_out_progbuf_ena  = head.progbuf_ena;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model.
module tb_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk;
   logic        nrst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_pc;
   logic [63:0] in_instr;
   logic        in_lf;
   logic        in_pf;
   logic        in_pb;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [63:0] out_instr;
   logic        out_lf;
   logic        out_pf;
   logic        out_pb;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [63:0] pc;
      logic [63:0] instr;
      logic        lf;
      logic        pf;
      logic        pb;
   } ent_t;

   ent_t mq[$];

   fetch_queue #(.abits(2), .RISCV_ARCH(64)) dut (
      .i_clk              (clk),
      .i_nrst             (nrst),
      .i_flush            (flush),
      .i_in_valid         (in_valid),
      .o_in_ready         (in_ready),
      .i_in_pc            (in_pc),
      .i_in_instr         (in_instr),
      .i_in_load_fault    (in_lf),
      .i_in_page_fault_x  (in_pf),
      .i_in_progbuf_ena   (in_pb),
      .o_out_valid        (out_valid),
      .i_out_ready        (out_ready),
      .o_out_pc           (out_pc),
      .o_out_instr        (out_instr),
      .o_out_load_fault   (out_lf),
      .o_out_page_fault_x (out_pf),
      .o_out_progbuf_ena  (out_pb),
      .o_count            (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [135:0] got;
   assign got = {out_valid, in_ready, count, out_pc, out_instr, out_lf, out_pf, out_pb};

   function automatic logic [135:0] exp_vec();
      logic ev;
      logic er;
      ev = (mq.size() != 0) && !flush;
      er = (mq.size() != DEPTH) && !flush;
      if (mq.size() == 0) begin
         return {ev, er, 3'd0, {64{1'b1}}, 64'd0, 3'b000};
      end
      return {ev, er, 3'(mq.size()), mq[0].pc, mq[0].instr, mq[0].lf, mq[0].pf, mq[0].pb};
   endfunction

   task automatic drive(input logic v, input logic [63:0] pc, input logic [63:0] instr,
                        input logic lf, input logic pf, input logic pb, input logic rdy,
                        input logic fl);
      in_valid  = v;
      in_pc     = pc;
      in_instr  = instr;
      in_lf     = lf;
      in_pf     = pf;
      in_pb     = pb;
      out_ready = rdy;
      flush     = fl;
   endtask

   // Advance one clock and apply the reference model's rules to the inputs held this cycle.
   task automatic tick();
      bit   pu;
      bit   po;
      ent_t e;
      pu = in_valid && (mq.size() < DEPTH) && !flush;
      po = out_ready && (mq.size() > 0) && !flush;
      e  = '{pc: in_pc, instr: in_instr, lf: in_lf, pf: in_pf, pb: in_pb};
      @(posedge clk);
      if (!nrst || flush) begin
         mq.delete();
      end else begin
         if (po) mq.delete(0);
         if (pu) mq.push_back(e);
      end
      #1;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      nrst = 1'b1;
      #1;
      n_cmp++;
      if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state got cnt=%0d rdy=%b vld=%b exp cnt=0 rdy=1 vld=0",
                  count, in_ready, out_valid);
      end
      n_cmp++;
      if (out_pc !== {64{1'b1}} || out_instr !== 64'd0 || {out_lf, out_pf, out_pb} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_head got pc=%h instr=%h flags=%b exp pc=all-ones instr=0 flags=000",
                  out_pc, out_instr, {out_lf, out_pf, out_pb});
      end
   endtask

   task automatic test_single();
      drive(1'b1, 64'h8000_0000, 64'h00000013_00000013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL single_no_bypass got vld=%b exp vld=0", out_valid);
      end
      tick();
      drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000 || count !== 3'd1
          || out_instr !== 64'h00000013_00000013) begin
         n_err++;
         $display("FAIL single_head got vld=%b pc=%h cnt=%0d instr=%h exp vld=1 pc=80000000 cnt=1",
                  out_valid, out_pc, count, out_instr);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || out_pc !== {64{1'b1}} || count !== 3'd0) begin
         n_err++;
         $display("FAIL single_drained got vld=%b pc=%h cnt=%0d exp vld=0 pc=all-ones cnt=0",
                  out_valid, out_pc, count);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 64'h1000 + 64'(4 * i), 64'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         n_cmp++;
         if (in_ready !== (i < 4)) begin
            n_err++;
            $display("FAIL fill_ready[%0d] got rdy=%b exp rdy=%b", i, in_ready, (i < 4));
         end
         tick();
      end
      n_cmp++;
      if (count !== 3'd4 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL fill_full got cnt=%0d rdy=%b exp cnt=4 rdy=0", count, in_ready);
      end
      // Full with a pop in the same cycle: push must still be refused.
      drive(1'b1, 64'hdead, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if (out_valid !== 1'b1 || out_pc !== 64'h1000 + 64'(4 * i)) begin
            n_err++;
            $display("FAIL fill_order[%0d] got vld=%b pc=%h exp vld=1 pc=%h",
                     i, out_valid, out_pc, 64'h1000 + 64'(4 * i));
         end
         if (i == 0) in_valid = 1'b0;
         tick();
      end
      n_cmp++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL fill_drained got cnt=%0d vld=%b exp cnt=0 vld=0", count, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 64'h2000 + 64'(4 * i), 64'(100 + i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         #1;
         if (i > 0) begin
            n_cmp++;
            if (out_valid !== 1'b1 || count !== 3'd1 || out_pc !== 64'h2000 + 64'(4 * (i - 1))) begin
               n_err++;
               $display("FAIL stream[%0d] got vld=%b cnt=%0d pc=%h exp vld=1 cnt=1 pc=%h",
                        i, out_valid, count, out_pc, 64'h2000 + 64'(4 * (i - 1)));
            end
         end
         tick();
      end
      drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      n_cmp++;
      if (out_pc !== 64'h2024) begin
         n_err++;
         $display("FAIL stream_last got pc=%h exp pc=2024", out_pc);
      end
      tick();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 64'h3100 + 64'(4 * i), 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 64'h3000, 64'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || count !== 3'd3) begin
         n_err++;
         $display("FAIL flush_cycle got vld=%b rdy=%b cnt=%0d exp vld=0 rdy=0 cnt=3",
                  out_valid, in_ready, count);
      end
      tick();
      drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      n_cmp++;
      if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL flush_after got cnt=%0d vld=%b rdy=%b exp cnt=0 vld=0 rdy=1",
                  count, out_valid, in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_dropped[%0d] got vld=%b pc=%h exp vld=0", i, out_valid, out_pc);
         end
      end
      // Flush while empty must leave the queue usable.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      n_cmp++;
      if (got !== exp_vec()) begin
         n_err++;
         $display("FAIL flush_empty got %h exp %h", got, exp_vec());
      end
   endtask

   task automatic test_flags();
      drive(1'b1, 64'h4000, 64'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 64'h4004, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 64'h4008, 64'h2222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      n_cmp++;
      if (out_pc !== 64'h4000 || {out_lf, out_pf, out_pb} !== 3'b000 || out_instr !== 64'h1111) begin
         n_err++;
         $display("FAIL flags_first got pc=%h flags=%b exp pc=4000 flags=000",
                  out_pc, {out_lf, out_pf, out_pb});
      end
      tick();
      n_cmp++;
      if (out_pc !== 64'h4004 || {out_lf, out_pf, out_pb} !== 3'b011 || out_instr !== 64'h0) begin
         n_err++;
         $display("FAIL flags_second got pc=%h flags=%b instr=%h exp pc=4004 flags=011 instr=0",
                  out_pc, {out_lf, out_pf, out_pb}, out_instr);
      end
      tick();
      n_cmp++;
      if (out_pc !== 64'h4008 || {out_lf, out_pf, out_pb} !== 3'b100) begin
         n_err++;
         $display("FAIL flags_third got pc=%h flags=%b exp pc=4008 flags=100",
                  out_pc, {out_lf, out_pf, out_pb});
      end
      tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 64'h5000 + 64'(4 * i), 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 64'h5100, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      nrst = 1'b0;
      tick();
      nrst = 1'b1;
      drive(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      n_cmp++;
      if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_mid got cnt=%0d vld=%b rdy=%b exp cnt=0 vld=0 rdy=1",
                  count, out_valid, in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_out[%0d] got vld=%b pc=%h exp vld=0", i, out_valid, out_pc);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
         nrst = ($urandom_range(0, 63) != 0);
         #1;
         n_cmp++;
         if (got !== exp_vec()) begin
            n_err++;
            $display("FAIL random[%0d] got %h exp %h", i, got, exp_vec());
         end
         tick();
      end
      nrst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_back_to_back();
      test_flush();
      test_flags();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the InstrFetch stage and the instruction decoder.
- Decouples fetch response timing from decoder stalls.
- Holds up to 2**abits fetched words, each with its pc and fault/progbuf flags; released in order over a valid/ready handshake.
- Flushed on any pipeline redirect (branch mispredict, trap, debug entry).

Parameters:
abits, 2, log2 of queue depth (DEPTH = 2**abits = 4 entries)
Data widths use RISCV_ARCH from river_cfg_pkg (64).

Ports:
i_clk  in  1  clock
i_nrst  in  1  reset, synchronous, active-low
i_flush  in  1  discard all queued entries
i_in_valid  in  1  fetch stage presents a word
o_in_ready  out  1  queue can accept a word this cycle
i_in_pc  in  RISCV_ARCH  pc of the word
i_in_instr  in  64  fetched instruction bits
i_in_load_fault  in  1  instruction access fault
i_in_page_fault_x  in  1  instruction page fault
i_in_progbuf_ena  in  1  word comes from the debug program buffer
o_out_valid  out  1  head entry valid
i_out_ready  in  1  decoder consumes head entry
o_out_pc  out  RISCV_ARCH  head pc
o_out_instr  out  64  head instruction
o_out_load_fault  out  1  head load fault
o_out_page_fault_x  out  1  head page fault
o_out_progbuf_ena  out  1  head progbuf flag
o_count  out  abits+1  number of stored entries, 0..DEPTH

Behaviour:
- Storage: circular array of DEPTH entries {pc, instr, load_fault, page_fault_x, progbuf_ena}.
  - wr_ptr and rd_ptr are abits wide and wrap naturally modulo DEPTH.
  - count register is abits+1 wide.
- Reset (i_nrst=0 at a rising edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Array contents need no reset.
- Output values:
  - o_in_ready=1 out of reset.
  - o_out_valid=0 out of reset.
  - When count==0: o_out_pc='1, o_out_instr=0, all flag outputs=0, o_count=0.
- Push = i_in_valid & o_in_ready.
  - Writes the entry at wr_ptr; wr_ptr+1.
- Pop = o_out_valid & i_out_ready.
  - rd_ptr+1.
- o_in_ready = (count != DEPTH) & !i_flush.
  - Registered terms only plus i_flush; no combinational path from i_out_ready.
  - When full, a same-cycle pop does NOT enable a push.
- o_out_valid = (count != 0) & !i_flush.
  - Head data driven combinationally from array[rd_ptr]; first-word fall-through.
- Latency: a word pushed in cycle N appears on the outputs in cycle N+1 if the queue was empty. Minimum latency is 1 cycle; there is no bypass.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop; pointers both advance.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- Flush priority:
  - i_flush=1 overrides push and pop.
  - Next cycle: count=0, wr_ptr=rd_ptr=0.
  - A word presented in the flush cycle is dropped; o_in_ready is 0 that cycle, so the fetch stage keeps it pending or re-issues it per its own redirect logic.
  - Flush while empty is harmless.
- Reset takes priority over flush.
  - Reset mid-operation empties the queue regardless of i_in_valid/i_out_ready.
- Fault and progbuf flags: stored and returned unmodified.
  - An entry with a fault set is queued and ordered like any other entry.
  - The instruction field is passed through as received.
- Full state (count==DEPTH): o_in_ready=0; i_in_* ignored.
- Empty state (count==0): o_out_valid=0; i_out_ready ignored.
- No underflow or overflow is reachable through the handshake.

Test Plan:
1. Reset, then single push pc=0x80000000, instr=0x00000013_00000013 -> next cycle o_out_valid=1, o_out_pc=0x80000000, o_count=1. Pop that cycle -> following cycle o_out_valid=0, o_out_pc='1, o_count=0.
2. Hold i_out_ready=0 and push 5 words, pc 0x1000..0x1010 step 4 -> o_in_ready drops after the 4th accepted push, o_count=4, the 5th word is not accepted. Then set i_out_ready=1 -> outputs pc 0x1000,0x1004,0x1008,0x100C in order.
3. Continuous push+pop for 10 cycles with pcs 0x2000.. -> o_count stays 1, pointers wrap past 3->0, output order matches input with exactly 1-cycle latency.
4. Fill 3 entries, assert i_flush together with i_in_valid=1 (pc 0x3000) -> o_out_valid=0 and o_in_ready=0 that cycle; next cycle o_count=0 and pc 0x3000 is never output.
5. Push an entry with i_in_page_fault_x=1, i_in_progbuf_ena=1, instr=0 between two normal entries -> emerges second with o_out_page_fault_x=1, o_out_progbuf_ena=1; neighbouring entries have the flags at 0.
6. Queue holding 2 entries, drive i_nrst=0 for one cycle while i_in_valid=1 and i_out_ready=1 -> after the edge o_count=0, o_out_valid=0, o_in_ready=1, and no entry is output.
